// File: rtl/alu_packet_parser.sv
// Byte-stream front end of the UART ALU: header parse, operand assembly,
// echo pass-through and discard of malformed packets.
module alu_packet_parser #(
   parameter logic [7:0] OP_ECHO = 8'hEC,
   parameter logic [7:0] OP_ADD  = 8'h01,
   parameter logic [7:0] OP_MUL  = 8'h02,
   parameter logic [7:0] OP_DIV  = 8'h03
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic [7:0]  echo_tdata,
   output logic        echo_tvalid,
   input  logic        echo_tready,
   output logic [7:0]  op_o,
   output logic        err_o
);

   typedef enum logic [3:0] {
      S_OPCODE,
      S_RSVD,
      S_LEN_LO,
      S_LEN_HI,
      S_CHECK,
      S_COLLECT,
      S_EMIT,
      S_ECHO,
      S_DRAIN
   } state_t;

   state_t      state;
   logic [15:0] len;
   logic [15:0] rem;
   logic [15:0] rem_c;
   logic [1:0]  cnt;
   logic [23:0] part;
   logic        take;
   logic        arith_ok;
   logic        ready_c;

   always_comb begin
      ready_c = 1'b0;
      unique case (state)
         S_OPCODE,
         S_RSVD,
         S_LEN_LO,
         S_LEN_HI,
         S_COLLECT,
         S_DRAIN:  ready_c = 1'b1;
         S_ECHO:   ready_c = echo_tready;
         default:  ready_c = 1'b0;
      endcase
   end

   // Gated by reset so the source sees no ready while the parser is held.
   assign s_axis_tready = rst_ni & ready_c;
   assign take          = s_axis_tvalid & s_axis_tready;
   assign echo_tdata    = s_axis_tdata;
   assign echo_tvalid   = (state == S_ECHO) & s_axis_tvalid;

   assign rem_c    = len - 16'd4;
   assign arith_ok = (((op_o == OP_ADD) || (op_o == OP_MUL))
                      && (rem_c[1:0] == 2'd0))
                  || ((op_o == OP_DIV) && (rem_c == 16'd8));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state         <= S_OPCODE;
         len           <= '0;
         rem           <= '0;
         cnt           <= '0;
         part          <= '0;
         op_o          <= '0;
         err_o         <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         err_o <= 1'b0;
         unique case (state)
            S_OPCODE: if (take) begin
               op_o  <= s_axis_tdata;
               state <= S_RSVD;
            end
            S_RSVD: if (take) state <= S_LEN_LO;
            S_LEN_LO: if (take) begin
               len[7:0] <= s_axis_tdata;
               state    <= S_LEN_HI;
            end
            S_LEN_HI: if (take) begin
               len[15:8] <= s_axis_tdata;
               state     <= S_CHECK;
            end
            S_CHECK: begin
               rem  <= rem_c;
               cnt  <= '0;
               part <= '0;
               if (len < 16'd4) begin
                  err_o <= 1'b1;
                  state <= S_OPCODE;
               end else if (rem_c == 16'd0) begin
                  err_o <= (op_o != OP_ECHO);
                  state <= S_OPCODE;
               end else if (op_o == OP_ECHO) begin
                  state <= S_ECHO;
               end else if (arith_ok) begin
                  state <= S_COLLECT;
               end else begin
                  err_o <= 1'b1;
                  state <= S_DRAIN;
               end
            end
            S_COLLECT: if (take) begin
               rem <= rem - 16'd1;
               cnt <= cnt + 2'd1;
               if (cnt == 2'd3) begin
                  m_axis_tdata  <= {s_axis_tdata, part};
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= (rem == 16'd1);
                  part          <= '0;
                  state         <= S_EMIT;
               end else begin
                  part <= {s_axis_tdata, part[23:8]};
               end
            end
            S_EMIT: if (m_axis_tready) begin
               m_axis_tvalid <= 1'b0;
               state         <= m_axis_tlast ? S_OPCODE : S_COLLECT;
            end
            S_ECHO,
            S_DRAIN: if (take) begin
               rem <= rem - 16'd1;
               if (rem == 16'd1) state <= S_OPCODE;
            end
            default: state <= S_OPCODE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_packet_parser.sv
// Bench for alu_packet_parser: directed packets plus randomized packets
// scored against a packet-level reference model.
module tb_alu_packet_parser;

   typedef logic [7:0] bq_t[$];

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b0;
   logic        m_axis_tlast;
   logic [7:0]  echo_tdata;
   logic        echo_tvalid;
   logic        echo_tready = 1'b0;
   logic [7:0]  op_o;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   logic [32:0] exp_words[$];
   logic [7:0]  exp_echo[$];
   int          exp_err;
   logic [32:0] got_words[$];
   logic [7:0]  got_echo[$];
   int          err_seen;
   int          mv_seen;

   bit m_rand = 0;
   bit m_force = 1;
   bit e_rand = 0;

   logic        hold_prev = 1'b0;
   logic [32:0] prev_word = '0;

   alu_packet_parser dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .echo_tdata    (echo_tdata),
      .echo_tvalid   (echo_tvalid),
      .echo_tready   (echo_tready),
      .op_o          (op_o),
      .err_o         (err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [32:0] obs,
                        input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_i) begin
      #1;
      m_axis_tready = m_rand ? 1'($urandom_range(0, 1)) : m_force;
      echo_tready   = e_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Handshakes seen at the negedge complete on the following posedge.
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("hold_valid", 33'(m_axis_tvalid), 33'd1);
            check("hold_word", {m_axis_tlast, m_axis_tdata}, prev_word);
         end
         if (m_axis_tvalid) begin
            mv_seen++;
            check("in_stall", 33'(s_axis_tready), 33'd0);
         end
         if (m_axis_tvalid && m_axis_tready)
            got_words.push_back({m_axis_tlast, m_axis_tdata});
         if (echo_tvalid && echo_tready)
            got_echo.push_back(echo_tdata);
         if (err_o) err_seen++;
         hold_prev = m_axis_tvalid && !m_axis_tready;
         prev_word = {m_axis_tlast, m_axis_tdata};
      end
   end

   function automatic void model(input bq_t p);
      logic [7:0] op;
      int len;
      int rem;
      int nw;
      logic [31:0] w;
      exp_words.delete();
      exp_echo.delete();
      exp_err = 0;
      op  = p[0];
      len = int'(p[2]) + 256 * int'(p[3]);
      if (len < 4) begin
         exp_err = 1;
         return;
      end
      rem = len - 4;
      if (op == 8'hEC) begin
         for (int i = 0; i < rem; i++) exp_echo.push_back(p[4+i]);
      end else if (op == 8'h01 || op == 8'h02 || op == 8'h03) begin
         if (rem == 0 || rem % 4 != 0 || (op == 8'h03 && rem != 8)) begin
            exp_err = 1;
         end else begin
            nw = rem / 4;
            for (int k = 0; k < nw; k++) begin
               w = {p[7+4*k], p[6+4*k], p[5+4*k], p[4+4*k]};
               exp_words.push_back({k == nw - 1, w});
            end
         end
      end else begin
         exp_err = 1;
      end
   endfunction

   function automatic bq_t mk(input logic [7:0] op, input int len);
      bq_t p;
      int n;
      p = {op, 8'($urandom), 8'(len), 8'(len >> 8)};
      n = (len < 4) ? 0 : len - 4;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      int  n;
      logic acc;
      n   = 0;
      acc = 1'b0;
      s_axis_tdata  = b;
      s_axis_tvalid = 1'b1;
      while (!acc && n < 2000) begin
         @(negedge clk_i);
         acc = s_axis_tready;
         n++;
         @(posedge clk_i);
         #1;
      end
      s_axis_tvalid = 1'b0;
      if (!acc) check("send_timeout", 33'(acc), 33'd1);
      if (m_rand && $urandom_range(0, 3) == 0) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic begin_pkt(input bq_t p);
      model(p);
      got_words.delete();
      got_echo.delete();
      err_seen = 0;
      mv_seen  = 0;
   endtask

   task automatic send_range(input bq_t p, input int from, input int upto);
      for (int i = from; i < upto; i++) send_byte(p[i]);
   endtask

   task automatic finish_pkt(input string tag, input logic [7:0] op);
      int n;
      n = 0;
      while ((got_words.size() < exp_words.size() ||
              got_echo.size() < exp_echo.size()) && n < 1000) begin
         @(posedge clk_i);
         n++;
      end
      repeat (4) @(posedge clk_i);
      #1;
      check({tag, "_nwords"}, 33'(got_words.size()), 33'(exp_words.size()));
      for (int i = 0; i < exp_words.size() && i < got_words.size(); i++)
         check({tag, "_word"}, got_words[i], exp_words[i]);
      check({tag, "_necho"}, 33'(got_echo.size()), 33'(exp_echo.size()));
      for (int i = 0; i < exp_echo.size() && i < got_echo.size(); i++)
         check({tag, "_echo"}, 33'(got_echo[i]), 33'(exp_echo[i]));
      check({tag, "_err"}, 33'(err_seen), 33'(exp_err));
      check({tag, "_op"}, 33'(op_o), 33'(op));
      if (exp_words.size() == 0)
         check({tag, "_no_mvalid"}, 33'(mv_seen), 33'd0);
   endtask

   task automatic run_pkt(input bq_t p, input string tag);
      begin_pkt(p);
      send_range(p, 0, p.size());
      finish_pkt(tag, p[0]);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, "_sready"}, 33'(s_axis_tready), 33'd0);
      check({tag, "_mvalid"}, 33'(m_axis_tvalid), 33'd0);
      check({tag, "_mlast"}, 33'(m_axis_tlast), 33'd0);
      check({tag, "_mdata"}, 33'(m_axis_tdata), 33'd0);
      check({tag, "_op"}, 33'(op_o), 33'd0);
      check({tag, "_err"}, 33'(err_o), 33'd0);
   endtask

   initial begin
      bq_t p;
      bq_t q;
      logic [7:0] op;
      int len;
      int sel;
      bit stall_ok;

      #2;
      check_reset_outs("rst0");
      repeat (2) @(posedge clk_i);
      #4 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check("rst0_sready_after", 33'(s_axis_tready), 33'd1);

      p = {8'h01, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
           8'hFD, 8'hFF, 8'hFF, 8'hFF};
      run_pkt(p, "add12");

      e_rand = 1;
      p = {8'hEC, 8'h00, 8'h08, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_pkt(p, "echo8");

      m_rand = 1;
      run_pkt(mk(8'h03, 16), "div16");
      run_pkt(mk(8'h01, 8), "add_after_div");
      run_pkt(mk(8'h7F, 6), "unk6");
      run_pkt(mk(8'h01, 3), "add_len3");
      run_pkt(mk(8'h02, 4), "mul_len4");
      run_pkt(mk(8'hEC, 4), "echo_len4");
      run_pkt(mk(8'h03, 12), "div12");

      m_rand  = 0;
      m_force = 0;
      p = {8'h02, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
           8'h55, 8'h66, 8'h77, 8'h88};
      begin_pkt(p);
      send_range(p, 0, 8);
      stall_ok = 1;
      fork
         send_range(p, 8, 12);
         begin
            repeat (50) begin
               @(negedge clk_i);
               if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b1 ||
                   m_axis_tdata !== 32'h44332211)
                  stall_ok = 0;
            end
            m_force = 1;
         end
      join
      finish_pkt("mul_stall", 8'h02);
      check("mul_stall_hold", 33'(stall_ok), 33'd1);

      for (int t = 0; t < 25; t++) begin
         m_rand = 1;
         sel = $urandom_range(0, 4);
         case (sel)
            0: op = 8'h01;
            1: op = 8'h02;
            2: op = 8'h03;
            3: op = 8'hEC;
            default: op = 8'(8'h10 + $urandom_range(0, 8'h60));
         endcase
         if ($urandom_range(0, 3) == 0)
            len = $urandom_range(0, 20);
         else if (sel == 0 || sel == 1)
            len = 4 + 4 * $urandom_range(1, 4);
         else if (sel == 2)
            len = 12;
         else
            len = 4 + $urandom_range(1, 10);
         run_pkt(mk(op, len), "rand");
      end

      m_rand = 0;
      m_force = 1;
      e_rand = 0;
      q = {8'h01, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      begin_pkt(q);
      send_range(q, 0, 6);
      #2 rst_ni = 1'b0;
      #1;
      check_reset_outs("rst_mid");
      repeat (2) @(posedge clk_i);
      #4 rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check("rst_mid_sready_after", 33'(s_axis_tready), 33'd1);
      p = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h12, 8'h34, 8'h56};
      run_pkt(p, "echo_after_rst");
      run_pkt(mk(8'h01, 12), "add_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_packet_parser.md
Name: alu_packet_parser

Overview:
- Byte-stream front end of the UART ALU. Sits between the uart_rx AXI-stream output and the ALU datapath/echo path.
- Parses the 4-byte header: opcode, reserved, length LSB, length MSB. Length is the total packet byte count, header included.
- For arithmetic opcodes, assembles the payload into little-endian 32-bit operand words with a last-word flag.
- For echo, forwards payload bytes unchanged. For unknown opcodes or malformed lengths, discards the payload and flags an error.

Parameters:
- OP_ECHO, 8'hEC, echo opcode.
- OP_ADD, 8'h01, add opcode.
- OP_MUL, 8'h02, multiply opcode.
- OP_DIV, 8'h03, divide opcode; requires exactly 2 operands.

Ports:
- clk_i  in  1  system clock (31.5 MHz PLL domain).
- rst_ni  in  1  asynchronous active-low reset.
- s_axis_tdata  in  8  byte from uart_rx.
- s_axis_tvalid  in  1  input byte valid.
- s_axis_tready  out  1  parser accepts byte.
- m_axis_tdata  out  32  assembled operand word.
- m_axis_tvalid  out  1  operand valid.
- m_axis_tready  in  1  ALU accepts operand.
- m_axis_tlast  out  1  final operand of packet.
- echo_tdata  out  8  echo payload byte.
- echo_tvalid  out  1  echo byte valid.
- echo_tready  in  1  echo sink ready.
- op_o  out  8  opcode of current packet.
- err_o  out  1  one-cycle pulse on malformed or unknown packet.

Behaviour:
- Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
- Reset values:
  - FSM returns to OPCODE; byte counter and operand shift register cleared.
  - op_o = 0; err_o = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0.
  - s_axis_tready = 0 during reset, 1 in the first cycle after deassertion.
- Transfer rule: a byte transfers when s_axis_tvalid && s_axis_tready on a rising clk_i edge.
- FSM states: OPCODE, RSVD, LEN_LO, LEN_HI, CHECK, COLLECT, EMIT, ECHO, DRAIN.
- OPCODE: accept byte, latch into op_o, go to RSVD.
- RSVD: accept and ignore the byte (any value), go to LEN_LO.
- LEN_LO / LEN_HI: capture len[7:0], then len[15:8]; go to CHECK.
- CHECK: one cycle, s_axis_tready = 0. Compute rem = len - 4 (16-bit) and decide:
  - len < 4: pulse err_o, go to OPCODE.
  - rem == 0: echo goes to OPCODE with no output; arithmetic opcodes pulse err_o and go to OPCODE.
  - OP_ECHO: go to ECHO.
  - OP_ADD / OP_MUL: rem must be a nonzero multiple of 4, else pulse err_o and go to DRAIN. If valid, go to COLLECT.
  - OP_DIV: rem must equal 8, else pulse err_o and go to DRAIN.
  - Any other opcode: pulse err_o, go to DRAIN.
- COLLECT:
  - s_axis_tready = 1.
  - Byte k of each word (k = 0..3) goes to bits [8k+7:8k]; the first byte received is the LSB.
  - Each accepted byte decrements rem.
  - On the 4th byte, go to EMIT. m_axis_tvalid rises the cycle after the 4th byte transfers. m_axis_tlast = (rem == 0 after that byte).
- EMIT:
  - s_axis_tready = 0; tdata, tlast and tvalid held stable until m_axis_tready.
  - On handshake: go to COLLECT if not last, else OPCODE. Clear m_axis_tvalid the next cycle.
- ECHO:
  - Combinational pass-through: echo_tdata = s_axis_tdata, echo_tvalid = s_axis_tvalid, s_axis_tready = echo_tready.
  - Each transfer decrements rem; go to OPCODE when rem reaches 0.
  - echo_tvalid = 0 in all other states.
- DRAIN: s_axis_tready = 1; discard rem bytes, then go to OPCODE.
- op_o: holds from OPCODE capture until the next packet's opcode byte is accepted.
- Rules at the boundaries:
  - Max len 16'hFFFF (rem 65531) handled without overflow.
  - Back-pressure from m_axis_tready or echo_tready stalls the input; no byte is ever dropped.
  - Reset mid-packet aborts the packet immediately and clears the partial word. The next byte after reset is parsed as an opcode.

Test Plan:
- ADD, len 16'h000C, operands 32'h00000005 then 32'hFFFFFFFD: two words 5 and FFFFFFFD; tlast only on the second; op_o = 01; err_o stays 0.
- Echo: bytes EC,00,08,00,DE,AD,BE,EF -> echo outputs DE,AD,BE,EF in order; m_axis_tvalid never asserts; parser returns to OPCODE.
- DIV with len 16'h0010 (3 operands): err_o pulses once in CHECK; 12 payload bytes drained; a following valid ADD packet parses correctly.
- Unknown opcode 8'h7F, len 6: err_o pulses; 2 bytes drained. ADD with len 3: err_o pulses and nothing is drained.
- MUL with m_axis_tready held low 50 cycles after the first word: s_axis_tready = 0 throughout; word held stable; no input byte lost; both words correct after release.
- Assert rst_ni low after 2 payload bytes of an ADD: outputs return to reset values asynchronously. After release, a fresh echo packet passes through correctly.
